// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: fixed-priority (init > wr > rd) owner of the RTC multiplexed AD bus
// Ports: clk, reset (async, active-low)
//   requesters : req_/addr_/data_ init, wr; req_rd/addr_rd; grant[2:0]={rd,wr,init}, busy, done, rd_data, rd_valid
//   RTC pins   : cs_n, ad_n, wr_n, rd_n, bus_out, bus_oe, bus_in
module rtc_bus_arbiter #(
    parameter int T_SU  = 2,
    parameter int T_PW  = 4,
    parameter int T_H   = 2,
    parameter int T_REC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_init,
    input  logic [7:0] addr_init,
    input  logic [7:0] data_init,
    input  logic       req_wr,
    input  logic [7:0] addr_wr,
    input  logic [7:0] data_wr,
    input  logic       req_rd,
    input  logic [7:0] addr_rd,
    output logic [2:0] grant,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in
);
    typedef enum logic [3:0] {IDLE, A_SU, A_PW, A_H, D_SU, D_PW, D_H, REC, DONE} state_t;

    // counter reload values: a state lasts reload+1 cycles, zero-length timings stretch to one cycle
    localparam logic [7:0] L_SU  = (T_SU  < 1) ? 8'd0 : 8'(T_SU  - 1);
    localparam logic [7:0] L_PW  = (T_PW  < 1) ? 8'd0 : 8'(T_PW  - 1);
    localparam logic [7:0] L_H   = (T_H   < 1) ? 8'd0 : 8'(T_H   - 1);
    localparam logic [7:0] L_REC = (T_REC < 1) ? 8'd0 : 8'(T_REC - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n, addr_q, addr_n, data_q, data_n, rd_data_n, bus_out_n;
    logic [2:0] grant_n;
    logic       cs_n_n, ad_n_n, wr_n_n, rd_n_n, bus_oe_n, busy_n, done_n, rd_valid_n;
    logic       addr_ph, data_ph, rd_t;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            addr_q   <= 8'd0;
            data_q   <= 8'd0;
            grant    <= 3'b000;
            rd_data  <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            cs_n     <= 1'b1;
            ad_n     <= 1'b1;
            wr_n     <= 1'b1;
            rd_n     <= 1'b1;
            bus_out  <= 8'd0;
            bus_oe   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            addr_q   <= addr_n;
            data_q   <= data_n;
            grant    <= grant_n;
            rd_data  <= rd_data_n;
            busy     <= busy_n;
            done     <= done_n;
            rd_valid <= rd_valid_n;
            cs_n     <= cs_n_n;
            ad_n     <= ad_n_n;
            wr_n     <= wr_n_n;
            rd_n     <= rd_n_n;
            bus_out  <= bus_out_n;
            bus_oe   <= bus_oe_n;
        end
    end

    // cnt is zero whenever a state is ready to advance; IDLE and DONE always sit at zero
    always_comb begin
        state_n   = state;
        cnt_n     = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
        grant_n   = grant;
        addr_n    = addr_q;
        data_n    = data_q;
        rd_data_n = rd_data;
        if (cnt == 8'd0) begin
            case (state)
                IDLE: if (req_init || req_wr || req_rd) begin
                    state_n = A_SU;
                    cnt_n   = L_SU;
                    grant_n = req_init ? 3'b001 : req_wr ? 3'b010 : 3'b100;
                    addr_n  = req_init ? addr_init : req_wr ? addr_wr : addr_rd;
                    data_n  = req_init ? data_init : req_wr ? data_wr : 8'd0;
                end
                A_SU: begin state_n = A_PW; cnt_n = L_PW;  end
                A_PW: begin state_n = A_H;  cnt_n = L_H;   end
                A_H:  begin state_n = D_SU; cnt_n = L_SU;  end
                D_SU: begin state_n = D_PW; cnt_n = L_PW;  end
                D_PW: begin
                    state_n   = D_H;
                    cnt_n     = L_H;
                    rd_data_n = grant[2] ? bus_in : rd_data;
                end
                D_H:  begin state_n = REC;  cnt_n = L_REC; end
                REC:  state_n = DONE;
                DONE: begin state_n = IDLE; grant_n = 3'b000; end
                default: state_n = IDLE;
            endcase
        end
        // outputs are decoded from the next state so the pins come straight off flops
        addr_ph    = state_n inside {A_SU, A_PW, A_H};
        data_ph    = state_n inside {D_SU, D_PW, D_H};
        rd_t       = grant_n[2];
        cs_n_n     = !(addr_ph || data_ph);
        ad_n_n     = !addr_ph;
        wr_n_n     = !(state_n == A_PW || (state_n == D_PW && !rd_t));
        rd_n_n     = !(state_n == D_PW && rd_t);
        bus_oe_n   = addr_ph || (data_ph && !rd_t);
        bus_out_n  = addr_ph ? addr_n : (data_ph && !rd_t) ? data_n : 8'd0;
        busy_n     = state_n != IDLE;
        done_n     = state_n == DONE;
        rd_valid_n = done_n && rd_t;
    end
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: directed stimulus with a queue-based scoreboard checked on every done pulse
module tb_rtc_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_init = 1'b0, req_wr = 1'b0, req_rd = 1'b0;
    logic [7:0] addr_init = 8'd0, data_init = 8'd0, addr_wr = 8'd0, data_wr = 8'd0, addr_rd = 8'd0;
    logic [2:0] grant;
    logic       busy, done, rd_valid, cs_n, ad_n, wr_n, rd_n, bus_oe;
    logic [7:0] rd_data, bus_out;
    logic [7:0] bus_in = 8'hEE;
    logic [7:0] rd_byte = 8'h00;

    rtc_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .req_init(req_init), .addr_init(addr_init), .data_init(data_init),
        .req_wr(req_wr), .addr_wr(addr_wr), .data_wr(data_wr),
        .req_rd(req_rd), .addr_rd(addr_rd),
        .grant(grant), .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] grant;
        logic [7:0] addr;
        logic [7:0] data;
        bit         rd;
        logic [7:0] rdd;
        int         delta;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0, n_fails = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // RTC model: drives the read byte only while rd_n is low, junk otherwise
    initial forever begin
        @(negedge clk);
        bus_in = !rd_n ? rd_byte : 8'hEE;
    end

    // monitor: per-transaction bus profile, compared against the scoreboard on done
    int         cyc = 0, start = 0, last_start = 0, gap = 0, hi_run = 0;
    int         a_len = 0, a_wr = 0, d_len = 0, d_wr = 0, d_rd = 0, d_oe = 0;
    bit         in_tx = 0, have_last = 0, unstable = 0;
    logic [7:0] a_val = 8'd0, d_val = 8'd0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            in_tx     = 0;
            have_last = 0;
            hi_run    = 0;
        end else begin
            chk("strobe_excl", int'(!wr_n && !rd_n), 0);
            chk("oe_vs_rd", int'(bus_oe && !rd_n), 0);
            if (!done) chk("rd_valid_pulse", int'(rd_valid), 0);
            if (cs_n) hi_run++;
            else begin
                if (!in_tx) begin
                    in_tx = 1; start = cyc; gap = hi_run; unstable = 0;
                    a_len = 0; a_wr = 0; d_len = 0; d_wr = 0; d_rd = 0; d_oe = 0;
                end
                hi_run = 0;
                if (!ad_n) begin
                    if (a_len > 0 && bus_out != a_val) unstable = 1;
                    a_val = bus_out;
                    a_len++;
                    if (!wr_n) a_wr++;
                end else begin
                    if (d_len > 0 && bus_out != d_val) unstable = 1;
                    d_val = bus_out;
                    d_len++;
                    if (!wr_n) d_wr++;
                    if (!rd_n) d_rd++;
                    if (bus_oe) d_oe++;
                end
            end
            if (done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("grant", int'(grant), int'(e.grant));
                    chk("busy", int'(busy), 1);
                    // first cs_n-low sample is cycle k+1, done is cycle k+21
                    chk("latency", cyc - start, 20);
                    chk("addr_len", a_len, 8);
                    chk("addr_wr_pw", a_wr, 4);
                    chk("addr_val", int'(a_val), int'(e.addr));
                    chk("data_len", d_len, 8);
                    chk("data_val", int'(d_val), int'(e.data));
                    chk("data_wr_pw", d_wr, e.rd ? 0 : 4);
                    chk("data_rd_pw", d_rd, e.rd ? 4 : 0);
                    chk("data_oe", d_oe, e.rd ? 0 : 8);
                    chk("bus_stable", int'(unstable), 0);
                    chk("rd_valid", int'(rd_valid), int'(e.rd));
                    chk("rd_data", int'(rd_data), int'(e.rdd));
                    if (e.delta != 0) begin
                        chk("restart", have_last ? start - last_start : -1, e.delta);
                        chk("rec_gap", int'(gap >= 4), 1);
                    end
                end
                last_start = start;
                have_last  = 1;
                in_tx      = 0;
            end
        end
    end

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    // {grant,busy,done,rd_data,rd_valid,cs_n,ad_n,wr_n,rd_n,bus_out,bus_oe} at reset
    localparam logic [26:0] RST_VAL = {3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};

    initial begin
        logic [7:0] model_rd;
        bit found;
        model_rd = 8'h00;
        @(posedge clk);
        // 1: reset held, requests toggling
        addr_wr = 8'h21;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_init = i[0];
            req_wr   = i[1];
            req_rd   = !i[0];
            chk("reset_outputs", int'({grant, busy, done, rd_data, rd_valid, cs_n, ad_n, wr_n, rd_n, bus_out, bus_oe}), int'(RST_VAL));
        end
        req_init = 0; req_wr = 0; req_rd = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        // 2: write 0x21 <- 0x00
        addr_wr = 8'h21; data_wr = 8'h00;
        exp_q.push_back('{3'b010, 8'h21, 8'h00, 1'b0, model_rd, 0});
        req_wr = 1;
        wait_done();
        @(posedge clk);
        req_wr = 0;
        // 3: read 0x31, RTC returns 0x45
        @(negedge clk);
        addr_rd = 8'h31; rd_byte = 8'h45; model_rd = 8'h45;
        exp_q.push_back('{3'b100, 8'h31, 8'h00, 1'b1, model_rd, 0});
        req_rd = 1;
        wait_done();
        @(posedge clk);
        req_rd = 0;
        // 4: init and read together; read follows at the next IDLE
        @(negedge clk);
        addr_init = 8'h05; data_init = 8'hA5; addr_rd = 8'h0C; rd_byte = 8'h3C;
        exp_q.push_back('{3'b001, 8'h05, 8'hA5, 1'b0, model_rd, 0});
        model_rd = 8'h3C;
        exp_q.push_back('{3'b100, 8'h0C, 8'h00, 1'b1, model_rd, 22});
        req_init = 1; req_rd = 1;
        wait_done();
        @(posedge clk);
        req_init = 0;
        wait_done();
        @(posedge clk);
        req_rd = 0;
        // 5: reset during the data write pulse, then a clean write
        @(negedge clk);
        addr_wr = 8'h40; data_wr = 8'h99;
        req_wr = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = !cs_n && ad_n && !wr_n;
        end
        if (!found) chk("data_pw_timeout", 0, 1);
        #2 reset = 0;
        #1 chk("reset_abort", int'({cs_n, wr_n, rd_n, bus_oe, busy, done, grant, rd_data}), int'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00}));
        req_wr = 0;
        model_rd = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        addr_wr = 8'h55; data_wr = 8'hC3;
        exp_q.push_back('{3'b010, 8'h55, 8'hC3, 1'b0, model_rd, 0});
        req_wr = 1;
        wait_done();
        @(posedge clk);
        req_wr = 0;
        // 6: init held through done is served twice, 22 cycles apart
        @(negedge clk);
        addr_init = 8'h7E; data_init = 8'h18;
        exp_q.push_back('{3'b001, 8'h7E, 8'h18, 1'b0, model_rd, 0});
        exp_q.push_back('{3'b001, 8'h7E, 8'h18, 1'b0, model_rd, 22});
        req_init = 1;
        wait_done();
        wait_done();
        @(posedge clk);
        req_init = 0;
        repeat (30) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end
endmodule
